// File: rtl/pid_coeff_loader_pkg.sv
// Shared definitions for the PID coefficient loader: frame layout, word order
// and FSM state encoding.
package pid_coeff_loader_pkg;

  localparam int NUM_COEFFS = 5;
  localparam int DEFAULT_REG_BITWIDTH = 32;

  // Word order on the wire; index 0 is shifted in first.
  localparam int A1_IDX = 0;
  localparam int A0_IDX = 1;
  localparam int B0_IDX = 2;
  localparam int B1_IDX = 3;
  localparam int B2_IDX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic int frame_bits(input int reg_bitwidth);
    return NUM_COEFFS * reg_bitwidth;
  endfunction

  // Words arrive first-in at the top of a left-shifting staging register.
  function automatic int word_offset(input int idx, input int reg_bitwidth);
    return (NUM_COEFFS - 1 - idx) * reg_bitwidth;
  endfunction

endpackage

// File: rtl/pid_coeff_loader_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, followed by an edge register
// that yields one-cycle rise/fall pulses aligned with the synchronized level.
module pid_coeff_loader_sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/pid_coeff_loader.sv
// Serial coefficient frame loader: shifts a5-word frame in from slow pins,
// holds it as pending and commits it to the PID coefficients on a PID strobe.
module pid_coeff_loader
  import pid_coeff_loader_pkg::*;
#(
  parameter int                              REG_BITWIDTH = DEFAULT_REG_BITWIDTH,
  parameter logic signed [REG_BITWIDTH-1:0]  DEF_A1 = '0,
  parameter logic signed [REG_BITWIDTH-1:0]  DEF_A0 = '0,
  parameter logic signed [REG_BITWIDTH-1:0]  DEF_B0 = '0,
  parameter logic signed [REG_BITWIDTH-1:0]  DEF_B1 = '0,
  parameter logic signed [REG_BITWIDTH-1:0]  DEF_B2 = '0
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            clk_en_PID_i,
  input  logic                            ser_clk_i,
  input  logic                            ser_data_i,
  input  logic                            ser_load_i,
  output logic signed [REG_BITWIDTH-1:0]  a1_reg_o,
  output logic signed [REG_BITWIDTH-1:0]  a0_reg_o,
  output logic signed [REG_BITWIDTH-1:0]  b0_reg_o,
  output logic signed [REG_BITWIDTH-1:0]  b1_reg_o,
  output logic signed [REG_BITWIDTH-1:0]  b2_reg_o,
  output logic                            busy_o,
  output logic                            pending_o,
  output logic                            frame_err_o,
  output logic [1:0]                      state_o
);

  localparam int FRAME_BITS = frame_bits(REG_BITWIDTH);
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic data_lvl, data_rise, data_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic load_lvl, load_rise, load_fall;
  logic unused_edges;

  pid_coeff_loader_sync_edge u_sync_clk (
    .clk_i(clk_i), .rstn_i(rstn_i), .pin(ser_clk_i),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  pid_coeff_loader_sync_edge u_sync_data (
    .clk_i(clk_i), .rstn_i(rstn_i), .pin(ser_data_i),
    .level(data_lvl), .rise(data_rise), .fall(data_fall)
  );

  pid_coeff_loader_sync_edge u_sync_load (
    .clk_i(clk_i), .rstn_i(rstn_i), .pin(ser_load_i),
    .level(load_lvl), .rise(load_rise), .fall(load_fall)
  );

  assign unused_edges = ^{data_rise, data_fall, sclk_lvl, sclk_fall, load_lvl};

  state_e                         state_q;
  logic [CNT_W-1:0]               bit_cnt_q;
  logic [FRAME_BITS-1:0]          staging_q;
  logic signed [REG_BITWIDTH-1:0] coef_q [NUM_COEFFS];
  logic        [REG_BITWIDTH-1:0] staged_word [NUM_COEFFS];

  always_comb begin
    for (int i = 0; i < NUM_COEFFS; i++) begin
      staged_word[i] = staging_q[word_offset(i, REG_BITWIDTH) +: REG_BITWIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      staging_q       <= '0;
      pending_o       <= 1'b0;
      frame_err_o     <= 1'b0;
      coef_q[A1_IDX]  <= DEF_A1;
      coef_q[A0_IDX]  <= DEF_A0;
      coef_q[B0_IDX]  <= DEF_B0;
      coef_q[B1_IDX]  <= DEF_B1;
      coef_q[B2_IDX]  <= DEF_B2;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (load_rise) begin
            if (pending_o) begin
              frame_err_o <= 1'b1;
            end else begin
              state_q     <= ST_SHIFT;
              bit_cnt_q   <= '0;
              frame_err_o <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          // The last bit wins over a simultaneous load fall: the frame is complete.
          if (sclk_rise && bit_cnt_q == LAST_BIT) begin
            staging_q <= {staging_q[FRAME_BITS-2:0], data_lvl};
            pending_o <= 1'b1;
            state_q   <= ST_HOLD;
          end else if (load_fall) begin
            frame_err_o <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (sclk_rise) begin
            staging_q <= {staging_q[FRAME_BITS-2:0], data_lvl};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // A new frame cannot start until the held one has been committed.
          if (load_rise) begin
            frame_err_o <= 1'b1;
          end
          if (clk_en_PID_i && pending_o) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
              coef_q[i] <= staged_word[i];
            end
            pending_o <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a1_reg_o = coef_q[A1_IDX];
  assign a0_reg_o = coef_q[A0_IDX];
  assign b0_reg_o = coef_q[B0_IDX];
  assign b1_reg_o = coef_q[B1_IDX];
  assign b2_reg_o = coef_q[B2_IDX];
  assign busy_o   = (state_q == ST_SHIFT);
  assign state_o  = state_q;

endmodule

// File: tb/tb_pid_coeff_loader.sv
// Self-checking bench for pid_coeff_loader: randomized frames against a
// frame-level model of pending/commit/error behaviour.
module tb_pid_coeff_loader;

  localparam int W = 32;
  localparam int NW = 5;
  localparam int FB = NW * W;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic clk_en_PID_i = 1'b0;
  logic ser_clk_i = 1'b0;
  logic ser_data_i = 1'b0;
  logic ser_load_i = 1'b0;
  logic signed [W-1:0] a1_reg_o, a0_reg_o, b0_reg_o, b1_reg_o, b2_reg_o;
  logic busy_o, pending_o, frame_err_o;
  logic [1:0] state_o;

  pid_coeff_loader #(
    .REG_BITWIDTH(W),
    .DEF_A1(32'sd5), .DEF_A0('0), .DEF_B0('0), .DEF_B1('0), .DEF_B2('0)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_PID_i(clk_en_PID_i),
    .ser_clk_i(ser_clk_i), .ser_data_i(ser_data_i), .ser_load_i(ser_load_i),
    .a1_reg_o(a1_reg_o), .a0_reg_o(a0_reg_o), .b0_reg_o(b0_reg_o),
    .b1_reg_o(b1_reg_o), .b2_reg_o(b2_reg_o),
    .busy_o(busy_o), .pending_o(pending_o), .frame_err_o(frame_err_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- model and scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];          // words of the accepted-but-uncommitted frame
  logic [W-1:0] exp_coef [NW];     // a1, a0, b0, b1, b2
  logic         exp_pending;
  logic         exp_err;
  logic [W-1:0] words [NW];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_coef[0] = 32'd5;
    for (int i = 1; i < NW; i++) exp_coef[i] = '0;
    exp_pending = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic model_frame_ok(input logic [W-1:0] w [NW]);
    exp_err = 1'b0;
    exp_pending = 1'b1;
    for (int i = 0; i < NW; i++) exp_q.push_back(w[i]);
  endtask

  task automatic model_commit();
    if (exp_pending) begin
      for (int i = 0; i < NW; i++) exp_coef[i] = exp_q.pop_front();
      exp_pending = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".a1"}, a1_reg_o, exp_coef[0]);
    check_eq({tag, ".a0"}, a0_reg_o, exp_coef[1]);
    check_eq({tag, ".b0"}, b0_reg_o, exp_coef[2]);
    check_eq({tag, ".b1"}, b1_reg_o, exp_coef[3]);
    check_eq({tag, ".b2"}, b2_reg_o, exp_coef[4]);
    check_eq({tag, ".pending"}, W'(pending_o), W'(exp_pending));
    check_eq({tag, ".err"}, W'(frame_err_o), W'(exp_err));
  endtask

  // ---------------- drivers (all inputs change on negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic b);
    ser_data_i = b;
    tick(4);
    ser_clk_i = 1'b1;
    tick(4);
    ser_clk_i = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [W-1:0] w [NW], input int k);
    // k = 0 is the first bit on the wire: a1[MSB]
    return w[k / W][W - 1 - (k % W)];
  endfunction

  task automatic send_bits(input logic [W-1:0] w [NW], input int first, input int count);
    for (int k = first; k < first + count; k++) send_bit(frame_bit(w, k));
  endtask

  task automatic load_up();
    ser_load_i = 1'b1;
    tick(4);
  endtask

  task automatic load_down();
    ser_load_i = 1'b0;
    tick(5);
  endtask

  task automatic pulse_en();
    clk_en_PID_i = 1'b1;
    tick(1);
    clk_en_PID_i = 1'b0;
    tick(2);
  endtask

  task automatic rand_words();
    for (int i = 0; i < NW; i++) words[i] = $urandom;
  endtask

  task automatic full_frame();
    load_up();
    send_bits(words, 0, FB);
    load_down();
    model_frame_ok(words);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    ser_load_i = 1'b0;
    ser_clk_i = 1'b0;
    clk_en_PID_i = 1'b0;
    tick(4);
    model_reset();
    check_all("reset");
    check_eq("reset.busy", W'(busy_o), '0);
    rstn_i = 1'b1;
    tick(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset();

    tick(100);
    check_all("idle100");

    // Directed frame with sign-boundary values
    words[0] = 32'h0000_0001; words[1] = 32'hFFFF_FFFF; words[2] = 32'h4000_0000;
    words[3] = 32'hC000_0000; words[4] = 32'h1234_5678;
    load_up();
    send_bits(words, 0, 40);
    check_eq("shift.busy", W'(busy_o), 32'd1);
    send_bits(words, 40, FB - 40);
    load_down();
    model_frame_ok(words);
    check_eq("hold.busy", W'(busy_o), '0);
    tick(20);
    check_all("directed.held");
    pulse_en();
    model_commit();
    check_all("directed.commit");

    // Abort after 70 bits, then a clean frame
    rand_words();
    load_up();
    send_bits(words, 0, 70);
    load_down();
    exp_err = 1'b1;
    check_all("abort");
    pulse_en();
    check_all("abort.strobe");
    rand_words();
    load_up();
    check_eq("restart.err_cleared", W'(frame_err_o), '0);
    send_bits(words, 0, FB);
    load_down();
    model_frame_ok(words);
    pulse_en();
    model_commit();
    check_all("after_abort.commit");

    // Second frame while the first is pending is rejected
    rand_words();
    full_frame();
    rand_words();
    load_up();
    send_bits(words, 0, FB);
    load_down();
    exp_err = 1'b1;
    check_all("reject");
    pulse_en();
    model_commit();
    check_all("reject.commit_first");

    // Strobe coincident with the last bit's capture does not commit
    rand_words();
    load_up();
    send_bits(words, 0, FB - 1);
    ser_data_i = frame_bit(words, FB - 1);
    tick(4);
    ser_clk_i = 1'b1;
    tick(2);
    clk_en_PID_i = 1'b1;
    tick(1);
    clk_en_PID_i = 1'b0;
    tick(1);
    ser_clk_i = 1'b0;
    tick(4);
    model_frame_ok(words);
    check_all("coincident");
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    load_down();
    check_all("hold_extra_edges");
    pulse_en();
    model_commit();
    check_all("coincident.commit");

    // Reset in the middle of a frame
    rand_words();
    load_up();
    send_bits(words, 0, 100);
    do_reset();
    rand_words();
    full_frame();
    pulse_en();
    model_commit();
    check_all("post_reset.commit");

    // Random frames, some strobed several times
    for (int r = 0; r < 4; r++) begin
      rand_words();
      full_frame();
      check_all("rand.held");
      repeat ($urandom_range(1, 2)) begin
        pulse_en();
        model_commit();
      end
      check_all("rand.commit");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
